mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, 8, counter and load/capture bus width in bits; legal range 2..32.
REQ-002 Parameter MAX_COUNT, 2**WIDTH-1, terminal value; legal range 1..2**WIDTH-1.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port enable  input  1  count advance qualifier.
REQ-006 Port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 Port sat_mode  input  1  boundary behaviour: 0 = wrap, 1 = saturate.
REQ-008 Port load  input  1  synchronous load strobe.
REQ-009 Port load_val  input  WIDTH  load value.
REQ-010 Port ovf_clr  input  1  clears sticky overflow flag.
REQ-011 Port capture  input  1  snapshot strobe.
REQ-012 Port out  output  WIDTH  registered count.
REQ-013 Port tc  output  1  registered one-cycle terminal-event pulse.
REQ-014 Port ovf  output  1  registered sticky boundary-event flag.
REQ-015 Port cap_val  output  WIDTH  registered snapshot of out.
REQ-016 Port cap_valid  output  1  registered one-cycle snapshot-valid pulse.

Function
REQ-017 Per-edge priority SHALL be: reset > load > enable count > hold.
REQ-018 load=1: out <= min(load_val, MAX_COUNT); no tc, ovf unchanged by load.
REQ-019 enable=1, up_dn=1, out<MAX_COUNT: out <= out+1.
REQ-020 enable=1, up_dn=1, out==MAX_COUNT: out <= 0 if sat_mode=0, out holds MAX_COUNT if sat_mode=1; boundary event.
REQ-021 enable=1, up_dn=0, out>0: out <= out-1.
REQ-022 enable=1, up_dn=0, out==0: out <= MAX_COUNT if sat_mode=0, out holds 0 if sat_mode=1; boundary event.
REQ-023 enable=0 and load=0: out holds; up_dn and sat_mode ignored.
REQ-024 Boundary event at edge N: tc=1 for exactly the cycle following edge N, else 0; repeated saturated attempts give tc=1 on each such cycle.
REQ-025 Boundary event sets ovf=1 at the same edge; ovf stays 1 until ovf_clr or reset.
REQ-026 ovf_clr=1 with simultaneous boundary event: ovf SHALL remain 1 (set wins).
REQ-027 out SHALL never exceed MAX_COUNT under any input sequence.
REQ-028 Arithmetic SHALL be WIDTH-bit unsigned; no intermediate value exceeds WIDTH bits after clamping.

Reset
REQ-029 reset=1 at an edge: out=0, tc=0, ovf=0, cap_val=0, cap_valid=0, regardless of other inputs.
REQ-030 Reset asserted mid-count SHALL abort count, load and capture in that cycle; counting resumes from 0 on the first edge with reset=0.

Configuration
REQ-031 Macro MOD_COUNTER_CAPTURE_EN defined: capture=1 at edge N latches pre-update out into cap_val and pulses cap_valid=1 for the cycle after edge N; capture simultaneous with load/count latches the old value.
REQ-032 Macro MOD_COUNTER_CAPTURE_EN undefined: ports retained, capture ignored, cap_val constant 0, cap_valid constant 0, no capture logic synthesised.

Verification (WIDTH=8, MAX_COUNT=9 unless stated)
REQ-033 Reset, enable=1, up_dn=1, sat_mode=0, 12 edges -> out 1..9,0,1,2; tc=1 only the cycle out=0; ovf=1 thereafter.
REQ-034 out=0, up_dn=0, sat_mode=1, enable=1 for 3 edges -> out stays 0, tc=1 on all 3 cycles, ovf=1; then ovf_clr=1 with enable=0 -> ovf=0.
REQ-035 load=1, load_val=200, enable=1 -> out=9 next cycle, tc=0; next edge up, wrap -> out=0, tc=1.
REQ-036 out=5 counting up, reset=1 with load=1, load_val=3, capture=1 -> out=0, cap_val=0, cap_valid=0, ovf=0.
REQ-037 Macro defined, out=7 counting up, capture=1 one edge -> cap_val=7, cap_valid=1 one cycle, out=8; macro undefined, same stimulus -> cap_val=0, cap_valid=0.
REQ-038 WIDTH=4, MAX_COUNT default 15, up wrap and down wrap from 0 -> out 15->0 and 0->15, tc pulse each, ovf sticky.

Source files
------------

// File: rtl/mod_counter_if.sv
// ----------------------------------------------------------------------------
// mod_counter_if
// Bundle of the control, load, capture and status signals of mod_counter.
// The clock and reset are not part of this bundle; they stay plain ports.
//
//   master (driver side)  : drives enable, up_dn, sat_mode, load, load_val,
//                           ovf_clr, capture; observes out, tc, ovf, cap_val,
//                           cap_valid
//   slave  (counter side) : the mirror image of master
// ----------------------------------------------------------------------------
interface mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up_dn;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic             capture;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;
    logic [WIDTH-1:0] cap_val;
    logic             cap_valid;

    modport master (
        output enable, up_dn, sat_mode, load, load_val, ovf_clr, capture,
        input  out, tc, ovf, cap_val, cap_valid
    );

    modport slave (
        input  enable, up_dn, sat_mode, load, load_val, ovf_clr, capture,
        output out, tc, ovf, cap_val, cap_valid
    );
endinterface

// File: rtl/mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
// Up/down modulo counter with terminal value MAX_COUNT, selectable wrap or
// saturate behaviour at the boundaries, clamped synchronous load, a one-cycle
// terminal pulse (tc), a sticky boundary flag (ovf) and an optional snapshot
// register (cap_val / cap_valid).
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - synchronous, active-high; clears every register
//   bus    - mod_counter_if.slave:
//              enable, up_dn, sat_mode, load, load_val, ovf_clr, capture (in)
//              out, tc, ovf, cap_val, cap_valid                         (out)
//
// Parameters:
//   WIDTH      - counter width in bits (2..32)
//   MAX_COUNT  - terminal value (1..2**WIDTH-1)
//
// Build option:
//   MOD_COUNTER_CAPTURE_EN - when defined, capture latches the pre-update
//   count into cap_val and pulses cap_valid for one cycle. When undefined,
//   capture is ignored and cap_val / cap_valid are tied to 0.
// ----------------------------------------------------------------------------
module mod_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);

    // Loads above the terminal value are pulled down to it so the count can
    // never leave 0..MAX_COUNT.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_COUNT) ? MAX_COUNT : v;
    endfunction

    // Value taken at a boundary: saturate holds the boundary, wrap jumps to
    // the opposite end of the range.
    function automatic logic [WIDTH-1:0] boundary_val(
        input logic             sat,
        input logic             up,
        input logic [WIDTH-1:0] cur
    );
        if (sat) begin
            return cur;
        end
        return up ? '0 : MAX_COUNT;
    endfunction

    logic [WIDTH-1:0] cnt_p1;
    logic             tc_p1;
    logic             ovf_p1;
    logic [WIDTH-1:0] cnt_nxt;
    logic             bnd;
    logic             count_evt;

    // Next count for an enabled step; bnd flags a boundary event.
    always_comb begin
        cnt_nxt = cnt_p1;
        bnd     = 1'b0;
        if (bus.up_dn) begin
            if (cnt_p1 >= MAX_COUNT) begin
                bnd     = 1'b1;
                cnt_nxt = boundary_val(bus.sat_mode, 1'b1, MAX_COUNT);
            end else begin
                cnt_nxt = cnt_p1 + 1'b1;
            end
        end else begin
            if (cnt_p1 == '0) begin
                bnd     = 1'b1;
                cnt_nxt = boundary_val(bus.sat_mode, 1'b0, '0);
            end else begin
                cnt_nxt = cnt_p1 - 1'b1;
            end
        end
    end

    // A boundary only counts when the enabled step actually happens, i.e.
    // load does not take precedence in the same cycle.
    assign count_evt = bus.enable && !bus.load && bnd;

    // ---- stage p1: count, terminal pulse, sticky flag ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1 <= '0;
            tc_p1  <= 1'b0;
            ovf_p1 <= 1'b0;
        end else begin
            if (bus.load) begin
                cnt_p1 <= clamp_load(bus.load_val);
            end else if (bus.enable) begin
                cnt_p1 <= cnt_nxt;
            end
            tc_p1 <= count_evt;
            // Setting beats clearing when both happen on the same edge.
            if (count_evt) begin
                ovf_p1 <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_p1 <= 1'b0;
            end
        end
    end

    assign bus.out = cnt_p1;
    assign bus.tc  = tc_p1;
    assign bus.ovf = ovf_p1;

`ifdef MOD_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_p1;
    logic             vld_p1;

    // ---- stage p1: snapshot of the count as it was before this edge ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.capture;
            if (bus.capture) begin
                cap_p1 <= cnt_p1;
            end
        end
    end

    assign bus.cap_val   = cap_p1;
    assign bus.cap_valid = vld_p1;
`else
    logic unused_capture;
    assign unused_capture = bus.capture;
    assign bus.cap_val    = '0;
    assign bus.cap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_mod_counter
// Directed bench for mod_counter. Two instances share clk/reset:
//   dut8 : WIDTH=8, MAX_COUNT=9
//   dut4 : WIDTH=4, MAX_COUNT default (15)
// Capture expectations follow MOD_COUNTER_CAPTURE_EN.
// ----------------------------------------------------------------------------
module tb_mod_counter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mod_counter_if #(.WIDTH(8)) if8 ();
    mod_counter_if #(.WIDTH(4)) if4 ();

    mod_counter #(.WIDTH(8), .MAX_COUNT(8'd9)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    mod_counter #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if8.enable = 1'b0; if8.up_dn = 1'b1; if8.sat_mode = 1'b0;
        if8.load = 1'b0; if8.load_val = '0; if8.ovf_clr = 1'b0; if8.capture = 1'b0;
        if4.enable = 1'b0; if4.up_dn = 1'b1; if4.sat_mode = 1'b0;
        if4.load = 1'b0; if4.load_val = '0; if4.ovf_clr = 1'b0; if4.capture = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Reset with every other input active must still clear everything.
        idle_inputs();
        reset = 1'b1;
        if8.enable = 1'b1; if8.load = 1'b1; if8.load_val = 8'd5;
        if8.capture = 1'b1; if8.ovf_clr = 1'b0;
        tick();
        n_cmp++; if (if8.out !== 8'd0) begin n_bad++; $display("FAIL reset out: got %0d want 0", if8.out); end
        n_cmp++; if (if8.tc !== 1'b0) begin n_bad++; $display("FAIL reset tc: got %b want 0", if8.tc); end
        n_cmp++; if (if8.ovf !== 1'b0) begin n_bad++; $display("FAIL reset ovf: got %b want 0", if8.ovf); end
        n_cmp++; if (if8.cap_val !== 8'd0) begin n_bad++; $display("FAIL reset cap_val: got %0d want 0", if8.cap_val); end
        n_cmp++; if (if8.cap_valid !== 1'b0) begin n_bad++; $display("FAIL reset cap_valid: got %b want 0", if8.cap_valid); end
        n_cmp++; if (if4.out !== 4'd0) begin n_bad++; $display("FAIL reset out4: got %0d want 0", if4.out); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_count_up_wrap();
        logic [7:0] e_out;
        logic       e_tc;
        logic       e_ovf;
        do_reset();
        if8.enable = 1'b1; if8.up_dn = 1'b1; if8.sat_mode = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            e_out = 8'(i % 10);
            e_tc  = (i == 10);
            e_ovf = (i >= 10);
            n_cmp++; if (if8.out !== e_out) begin n_bad++; $display("FAIL up_wrap out[%0d]: got %0d want %0d", i, if8.out, e_out); end
            n_cmp++; if (if8.tc !== e_tc) begin n_bad++; $display("FAIL up_wrap tc[%0d]: got %b want %b", i, if8.tc, e_tc); end
            n_cmp++; if (if8.ovf !== e_ovf) begin n_bad++; $display("FAIL up_wrap ovf[%0d]: got %b want %b", i, if8.ovf, e_ovf); end
        end
        idle_inputs();
    endtask

    task automatic test_down_saturate();
        do_reset();
        if8.enable = 1'b1; if8.up_dn = 1'b0; if8.sat_mode = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (if8.out !== 8'd0) begin n_bad++; $display("FAIL dn_sat out[%0d]: got %0d want 0", i, if8.out); end
            n_cmp++; if (if8.tc !== 1'b1) begin n_bad++; $display("FAIL dn_sat tc[%0d]: got %b want 1", i, if8.tc); end
            n_cmp++; if (if8.ovf !== 1'b1) begin n_bad++; $display("FAIL dn_sat ovf[%0d]: got %b want 1", i, if8.ovf); end
        end
        if8.enable = 1'b0; if8.ovf_clr = 1'b1;
        tick();
        n_cmp++; if (if8.ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr ovf: got %b want 0", if8.ovf); end
        n_cmp++; if (if8.tc !== 1'b0) begin n_bad++; $display("FAIL ovf_clr tc: got %b want 0", if8.tc); end
        n_cmp++; if (if8.out !== 8'd0) begin n_bad++; $display("FAIL ovf_clr out: got %0d want 0", if8.out); end
        idle_inputs();
    endtask

    task automatic test_load_clamp();
        // ovf is 0 here; load must not touch it.
        if8.load = 1'b1; if8.load_val = 8'd200; if8.enable = 1'b1;
        if8.up_dn = 1'b1; if8.sat_mode = 1'b0;
        tick();
        n_cmp++; if (if8.out !== 8'd9) begin n_bad++; $display("FAIL load_clamp out: got %0d want 9", if8.out); end
        n_cmp++; if (if8.tc !== 1'b0) begin n_bad++; $display("FAIL load_clamp tc: got %b want 0", if8.tc); end
        n_cmp++; if (if8.ovf !== 1'b0) begin n_bad++; $display("FAIL load_clamp ovf: got %b want 0", if8.ovf); end
        if8.load = 1'b0;
        tick();
        n_cmp++; if (if8.out !== 8'd0) begin n_bad++; $display("FAIL load_wrap out: got %0d want 0", if8.out); end
        n_cmp++; if (if8.tc !== 1'b1) begin n_bad++; $display("FAIL load_wrap tc: got %b want 1", if8.tc); end
        n_cmp++; if (if8.ovf !== 1'b1) begin n_bad++; $display("FAIL load_wrap ovf: got %b want 1", if8.ovf); end
        if8.load = 1'b1; if8.load_val = 8'd4; if8.enable = 1'b0;
        tick();
        n_cmp++; if (if8.out !== 8'd4) begin n_bad++; $display("FAIL load_inrange out: got %0d want 4", if8.out); end
        n_cmp++; if (if8.ovf !== 1'b1) begin n_bad++; $display("FAIL load_inrange ovf: got %b want 1", if8.ovf); end
        idle_inputs();
    endtask

    task automatic test_set_beats_clear();
        if8.load = 1'b1; if8.load_val = 8'd9;
        tick();
        // Up saturate at MAX: holds 9, fires tc.
        if8.load = 1'b0; if8.enable = 1'b1; if8.up_dn = 1'b1; if8.sat_mode = 1'b1;
        tick();
        n_cmp++; if (if8.out !== 8'd9) begin n_bad++; $display("FAIL up_sat out: got %0d want 9", if8.out); end
        n_cmp++; if (if8.tc !== 1'b1) begin n_bad++; $display("FAIL up_sat tc: got %b want 1", if8.tc); end
        // Wrap with ovf_clr on the same edge: flag stays set.
        if8.sat_mode = 1'b0; if8.ovf_clr = 1'b1;
        tick();
        n_cmp++; if (if8.out !== 8'd0) begin n_bad++; $display("FAIL set_wins out: got %0d want 0", if8.out); end
        n_cmp++; if (if8.ovf !== 1'b1) begin n_bad++; $display("FAIL set_wins ovf: got %b want 1", if8.ovf); end
        n_cmp++; if (if8.tc !== 1'b1) begin n_bad++; $display("FAIL set_wins tc: got %b want 1", if8.tc); end
        if8.enable = 1'b0;
        tick();
        n_cmp++; if (if8.ovf !== 1'b0) begin n_bad++; $display("FAIL clr_after ovf: got %b want 0", if8.ovf); end
        idle_inputs();
    endtask

    task automatic test_hold();
        if8.load = 1'b1; if8.load_val = 8'd6;
        tick();
        if8.load = 1'b0; if8.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if8.up_dn = i[0]; if8.sat_mode = i[1];
            tick();
            n_cmp++; if (if8.out !== 8'd6) begin n_bad++; $display("FAIL hold out[%0d]: got %0d want 6", i, if8.out); end
            n_cmp++; if (if8.tc !== 1'b0) begin n_bad++; $display("FAIL hold tc[%0d]: got %b want 0", i, if8.tc); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_abort();
        if8.load = 1'b1; if8.load_val = 8'd4;
        tick();
        if8.load = 1'b0; if8.enable = 1'b1; if8.up_dn = 1'b1;
        tick();
        n_cmp++; if (if8.out !== 8'd5) begin n_bad++; $display("FAIL abort pre out: got %0d want 5", if8.out); end
        reset = 1'b1; if8.load = 1'b1; if8.load_val = 8'd3; if8.capture = 1'b1;
        tick();
        n_cmp++; if (if8.out !== 8'd0) begin n_bad++; $display("FAIL abort out: got %0d want 0", if8.out); end
        n_cmp++; if (if8.cap_val !== 8'd0) begin n_bad++; $display("FAIL abort cap_val: got %0d want 0", if8.cap_val); end
        n_cmp++; if (if8.cap_valid !== 1'b0) begin n_bad++; $display("FAIL abort cap_valid: got %b want 0", if8.cap_valid); end
        n_cmp++; if (if8.ovf !== 1'b0) begin n_bad++; $display("FAIL abort ovf: got %b want 0", if8.ovf); end
        reset = 1'b0; if8.load = 1'b0; if8.capture = 1'b0;
        tick();
        n_cmp++; if (if8.out !== 8'd1) begin n_bad++; $display("FAIL abort resume out: got %0d want 1", if8.out); end
        idle_inputs();
    endtask

    task automatic test_capture();
        logic [7:0] e_cap;
        logic       e_vld;
        if8.load = 1'b1; if8.load_val = 8'd7;
        tick();
        if8.load = 1'b0; if8.enable = 1'b1; if8.up_dn = 1'b1; if8.capture = 1'b1;
        tick();
`ifdef MOD_COUNTER_CAPTURE_EN
        e_cap = 8'd7; e_vld = 1'b1;
`else
        e_cap = 8'd0; e_vld = 1'b0;
`endif
        n_cmp++; if (if8.out !== 8'd8) begin n_bad++; $display("FAIL capture out: got %0d want 8", if8.out); end
        n_cmp++; if (if8.cap_val !== e_cap) begin n_bad++; $display("FAIL capture cap_val: got %0d want %0d", if8.cap_val, e_cap); end
        n_cmp++; if (if8.cap_valid !== e_vld) begin n_bad++; $display("FAIL capture cap_valid: got %b want %b", if8.cap_valid, e_vld); end
        if8.capture = 1'b0;
        tick();
        n_cmp++; if (if8.cap_valid !== 1'b0) begin n_bad++; $display("FAIL capture pulse cap_valid: got %b want 0", if8.cap_valid); end
        n_cmp++; if (if8.cap_val !== e_cap) begin n_bad++; $display("FAIL capture hold cap_val: got %0d want %0d", if8.cap_val, e_cap); end
        // Capture together with load snapshots the old count (9).
        if8.enable = 1'b0; if8.load = 1'b1; if8.load_val = 8'd2; if8.capture = 1'b1;
        tick();
`ifdef MOD_COUNTER_CAPTURE_EN
        e_cap = 8'd9;
`else
        e_cap = 8'd0;
`endif
        n_cmp++; if (if8.out !== 8'd2) begin n_bad++; $display("FAIL cap_load out: got %0d want 2", if8.out); end
        n_cmp++; if (if8.cap_val !== e_cap) begin n_bad++; $display("FAIL cap_load cap_val: got %0d want %0d", if8.cap_val, e_cap); end
        idle_inputs();
    endtask

    task automatic test_width4();
        do_reset();
        if4.load = 1'b1; if4.load_val = 4'hF;
        tick();
        n_cmp++; if (if4.out !== 4'd15) begin n_bad++; $display("FAIL w4 load out: got %0d want 15", if4.out); end
        n_cmp++; if (if4.tc !== 1'b0) begin n_bad++; $display("FAIL w4 load tc: got %b want 0", if4.tc); end
        if4.load = 1'b0; if4.enable = 1'b1; if4.up_dn = 1'b1; if4.sat_mode = 1'b0;
        tick();
        n_cmp++; if (if4.out !== 4'd0) begin n_bad++; $display("FAIL w4 up_wrap out: got %0d want 0", if4.out); end
        n_cmp++; if (if4.tc !== 1'b1) begin n_bad++; $display("FAIL w4 up_wrap tc: got %b want 1", if4.tc); end
        n_cmp++; if (if4.ovf !== 1'b1) begin n_bad++; $display("FAIL w4 up_wrap ovf: got %b want 1", if4.ovf); end
        if4.up_dn = 1'b0;
        tick();
        n_cmp++; if (if4.out !== 4'd15) begin n_bad++; $display("FAIL w4 dn_wrap out: got %0d want 15", if4.out); end
        n_cmp++; if (if4.tc !== 1'b1) begin n_bad++; $display("FAIL w4 dn_wrap tc: got %b want 1", if4.tc); end
        if4.enable = 1'b0;
        tick();
        n_cmp++; if (if4.tc !== 1'b0) begin n_bad++; $display("FAIL w4 idle tc: got %b want 0", if4.tc); end
        n_cmp++; if (if4.ovf !== 1'b1) begin n_bad++; $display("FAIL w4 sticky ovf: got %b want 1", if4.ovf); end
        n_cmp++; if (if4.out !== 4'd15) begin n_bad++; $display("FAIL w4 idle out: got %0d want 15", if4.out); end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_count_up_wrap();
        test_down_saturate();
        test_load_clamp();
        test_set_beats_clear();
        test_hold();
        test_reset_abort();
        test_capture();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
